// File: rtl/frame_draw_arbiter.sv
// Per-frame scheduler: one update pulse per frame tick, then grants the VGA write port to sky, catcher, score in turn.
// Optional macro FRAME_DRAW_ARBITER_OVERRUN_EN adds overrun_count (frame ticks dropped while busy).
module frame_draw_arbiter #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int X_W            = 8,
  parameter int Y_W            = 7,
  parameter int C_W            = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           frame_tick,
  input  logic           finish_game,
  output logic           update,
  output logic           draw_squares,
  output logic           draw_catcher,
  output logic           draw_score,
  input  logic [X_W-1:0] x_sky,
  input  logic [Y_W-1:0] y_sky,
  input  logic [C_W-1:0] color_sky,
  input  logic           plot_sky,
  input  logic           finish_drawing_squares,
  input  logic [X_W-1:0] x_catcher,
  input  logic [Y_W-1:0] y_catcher,
  input  logic [C_W-1:0] color_catcher,
  input  logic           plot_catcher,
  input  logic           finish_drawing_catcher,
  input  logic [X_W-1:0] x_score,
  input  logic [Y_W-1:0] y_score,
  input  logic [C_W-1:0] color_score,
  input  logic           plot_score,
  input  logic           finish_drawing_score,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] color,
  output logic           plot,
  output logic           timeout_flag,
  output logic           busy
`ifdef FRAME_DRAW_ARBITER_OVERRUN_EN
  ,
  output logic [7:0]     overrun_count
`endif
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UPD   = 3'd1,
    S_SKY   = 3'd2,
    S_CATCH = 3'd3,
    S_SCORE = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t          state_q;
  logic            start_q;
  logic            update_q;
  logic            draw_sky_q;
  logic            draw_catch_q;
  logic            draw_score_q;
  logic            busy_q;
  logic            timeout_q;
  logic [WD_W-1:0] wdog_q;
  logic [X_W-1:0]  x_q;
  logic [Y_W-1:0]  y_q;
  logic [C_W-1:0]  color_q;
  logic            plot_q;
  logic            wd_expired_s;

  assign wd_expired_s = (wdog_q == WD_LAST);

  // Frame sequencer: grants, update pulse, watchdog and sticky timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      update_q     <= 1'b0;
      draw_sky_q   <= 1'b0;
      draw_catch_q <= 1'b0;
      draw_score_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      start_q  <= start_q | start;
      update_q <= 1'b0;
      wdog_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (start_q && frame_tick) begin
            state_q  <= S_UPD;
            update_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_UPD: begin
          state_q    <= S_SKY;
          draw_sky_q <= 1'b1;
        end
        S_SKY: begin
          if (finish_drawing_squares || wd_expired_s) begin
            state_q      <= S_CATCH;
            draw_sky_q   <= 1'b0;
            draw_catch_q <= 1'b1;
            if (!finish_drawing_squares) timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_CATCH: begin
          if (finish_drawing_catcher || wd_expired_s) begin
            state_q      <= S_SCORE;
            draw_catch_q <= 1'b0;
            draw_score_q <= 1'b1;
            if (!finish_drawing_catcher) timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_SCORE: begin
          if (finish_drawing_score || wd_expired_s) begin
            state_q      <= finish_game ? S_OVER : S_IDLE;
            draw_score_q <= 1'b0;
            busy_q       <= 1'b0;
            if (!finish_drawing_score) timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_OVER: begin
          state_q <= S_OVER;
        end
        default: begin
          state_q      <= S_IDLE;
          draw_sky_q   <= 1'b0;
          draw_catch_q <= 1'b0;
          draw_score_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Pixel port mux; coordinates hold outside the drawing states so the adapter sees stable values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
    end else begin
      case (state_q)
        S_SKY: begin
          x_q     <= x_sky;
          y_q     <= y_sky;
          color_q <= color_sky;
          plot_q  <= plot_sky;
        end
        S_CATCH: begin
          x_q     <= x_catcher;
          y_q     <= y_catcher;
          color_q <= color_catcher;
          plot_q  <= plot_catcher;
        end
        S_SCORE: begin
          x_q     <= x_score;
          y_q     <= y_score;
          color_q <= color_score;
          plot_q  <= plot_score;
        end
        default: begin
          plot_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_DRAW_ARBITER_OVERRUN_EN
  logic [7:0] overrun_q;

  // Saturating count of frame ticks that arrive while a frame is still in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 8'd0;
    end else if (frame_tick && busy_q && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_count = overrun_q;
`endif

  assign update       = update_q;
  assign draw_squares = draw_sky_q;
  assign draw_catcher = draw_catch_q;
  assign draw_score   = draw_score_q;
  assign busy         = busy_q;
  assign timeout_flag = timeout_q;
  assign x            = x_q;
  assign y            = y_q;
  assign color        = color_q;
  assign plot         = plot_q;

endmodule

// File: tb/tb_frame_draw_arbiter.sv
// Scoreboard bench for frame_draw_arbiter: per-cycle grant vectors and pixel-port values are queued and compared.
module tb_frame_draw_arbiter;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int PW  = X_W + Y_W + C_W + 1;

  logic           clock, reset, start, frame_tick, finish_game;
  logic           update, draw_squares, draw_catcher, draw_score;
  logic [X_W-1:0] x_sky, x_catcher, x_score, x;
  logic [Y_W-1:0] y_sky, y_catcher, y_score, y;
  logic [C_W-1:0] color_sky, color_catcher, color_score, color;
  logic           plot_sky, plot_catcher, plot_score, plot;
  logic           fin_sq, fin_c, fin_s;
  logic           timeout_flag, busy;
`ifdef FRAME_DRAW_ARBITER_OVERRUN_EN
  logic [7:0]     overrun_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0]              grant_q[$];
  logic [PW-1:0]           pix_q[$];
  logic [X_W+Y_W+C_W-1:0]  last_xyc;

  frame_draw_arbiter #(.TIMEOUT_CYCLES(16), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick), .finish_game(finish_game),
    .update(update), .draw_squares(draw_squares), .draw_catcher(draw_catcher), .draw_score(draw_score),
    .x_sky(x_sky), .y_sky(y_sky), .color_sky(color_sky), .plot_sky(plot_sky),
    .finish_drawing_squares(fin_sq),
    .x_catcher(x_catcher), .y_catcher(y_catcher), .color_catcher(color_catcher), .plot_catcher(plot_catcher),
    .finish_drawing_catcher(fin_c),
    .x_score(x_score), .y_score(y_score), .color_score(color_score), .plot_score(plot_score),
    .finish_drawing_score(fin_s),
    .x(x), .y(y), .color(color), .plot(plot), .timeout_flag(timeout_flag), .busy(busy)
`ifdef FRAME_DRAW_ARBITER_OVERRUN_EN
    , .overrun_count(overrun_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Randomise every client's pixel inputs and queue the value the port must show one cycle later.
  task automatic drive_pixels(input logic [4:0] g, input bit fixed);
    x_sky         = fixed ? 8'd12 : 8'($urandom_range(255));
    y_sky         = fixed ? 7'd34 : 7'($urandom_range(127));
    color_sky     = fixed ? 3'd3  : 3'($urandom_range(7));
    plot_sky      = fixed ? 1'b1  : 1'($urandom_range(1));
    x_catcher     = 8'($urandom_range(255));
    y_catcher     = 7'($urandom_range(127));
    color_catcher = 3'($urandom_range(7));
    plot_catcher  = 1'($urandom_range(1));
    x_score       = 8'($urandom_range(255));
    y_score       = 7'($urandom_range(127));
    color_score   = 3'($urandom_range(7));
    plot_score    = 1'($urandom_range(1));
    if (g[3]) begin
      last_xyc = {x_sky, y_sky, color_sky};
      pix_q.push_back({last_xyc, plot_sky});
    end else if (g[2]) begin
      last_xyc = {x_catcher, y_catcher, color_catcher};
      pix_q.push_back({last_xyc, plot_catcher});
    end else if (g[1]) begin
      last_xyc = {x_score, y_score, color_score};
      pix_q.push_back({last_xyc, plot_score});
    end else begin
      pix_q.push_back({last_xyc, 1'b0});
    end
  endtask

  // One frame from IDLE: grant vector {update, sky, catcher, score, busy} expected on each cycle.
  task automatic run_frame(input int ns, input int nc, input int nr, input bit tick_catch,
                           input bit no_sky_fin, input bit stray, input bit fin_game);
    logic [4:0]    e, nxt, obs;
    logic [PW-1:0] pe, po;
    bit            prev_sky;
    int            step;
    grant_q.delete();
    pix_q.delete();
    grant_q.push_back(5'b10001);
    repeat (ns) grant_q.push_back(5'b01001);
    repeat (nc) grant_q.push_back(5'b00101);
    repeat (nr) grant_q.push_back(5'b00011);
    repeat (2) grant_q.push_back(5'b00000);
    finish_game = fin_game;
    frame_tick  = 1'b1;
    drive_pixels(5'b00000, 1'b0);
    prev_sky = 1'b0;
    step     = 0;
    while (grant_q.size() > 0) begin
      @(negedge clock);
      frame_tick = 1'b0;
      fin_sq = 1'b0; fin_c = 1'b0; fin_s = 1'b0;
      e   = grant_q.pop_front();
      obs = {update, draw_squares, draw_catcher, draw_score, busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL grant step %0d: got %b, want %b", step, obs, e);
      end
      pe = pix_q.pop_front();
      po = {x, y, color, plot};
      checks++;
      if (po !== pe) begin
        errors++;
        $display("FAIL pixel step %0d: got %h, want %h", step, po, pe);
      end
      nxt = (grant_q.size() > 0) ? grant_q[0] : 5'b00000;
      if (stray && e[3]) begin
        fin_c = 1'b1;
        fin_s = 1'b1;
      end
      if (e[3] && !nxt[3] && !no_sky_fin) fin_sq = 1'b1;
      if (e[2] && !nxt[2]) fin_c = 1'b1;
      if (e[1] && !nxt[1]) fin_s = 1'b1;
      if (tick_catch && e[2]) frame_tick = 1'b1;
      if (grant_q.size() > 0) drive_pixels(e, e[3] && !prev_sky);
      prev_sky = e[3];
      step++;
    end
    finish_game = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({update, draw_squares, draw_catcher, draw_score, busy, plot} !== 6'b0) begin
      errors++;
      $display("FAIL %s: got upd/draw/busy/plot %b, want 000000", name,
               {update, draw_squares, draw_catcher, draw_score, busy, plot});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; finish_game = 1'b0;
    fin_sq = 1'b0; fin_c = 1'b0; fin_s = 1'b0;
    drive_pixels(5'b00000, 1'b0);
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    check_quiet("reset_ctrl");
    checks++;
    if ({x, y, color, timeout_flag} !== 19'd0) begin
      errors++;
      $display("FAIL reset_data: got %h, want 0", {x, y, color, timeout_flag});
    end
    last_xyc = '0;
    reset = 1'b1;
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_quiet("tick_before_start");
      frame_tick = (i % 2 == 0);
    end
    @(negedge clock);
    frame_tick = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_sequence();
    run_frame(5, 3, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL seq_timeout: got %b, want 0", timeout_flag);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(4, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_DRAW_ARBITER_OVERRUN_EN
    checks++;
    if (overrun_count !== 8'd3) begin
      errors++;
      $display("FAIL overrun_count: got %0d, want 3", overrun_count);
    end
`endif
    run_frame(2, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_DRAW_ARBITER_OVERRUN_EN
    checks++;
    if (overrun_count !== 8'd3) begin
      errors++;
      $display("FAIL overrun_hold: got %0d, want 3", overrun_count);
    end
`endif
  endtask

  task automatic test_watchdog();
    run_frame(16, 3, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL wd_flag: got %b, want 1", timeout_flag);
    end
    run_frame(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: got %b, want 1", timeout_flag);
    end
  endtask

  task automatic test_game_over();
    run_frame(2, 2, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_quiet("over_quiet");
      checks++;
      if ({x, y, color} !== last_xyc) begin
        errors++;
        $display("FAIL over_hold: got %h, want %h", {x, y, color}, last_xyc);
      end
      frame_tick = (i % 2 == 0);
      plot_sky   = 1'b1;
      x_sky      = 8'($urandom_range(255));
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_async_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    for (int i = 0; i < 10 && !draw_squares; i++) @(negedge clock);
    checks++;
    if (draw_squares !== 1'b1) begin
      errors++;
      $display("FAIL ar_reach_sky: got %b, want 1", draw_squares);
    end
    plot_sky = 1'b1;
    x_sky    = 8'd77;
    @(negedge clock);
    checks++;
    if ({plot, x} !== {1'b1, 8'd77}) begin
      errors++;
      $display("FAIL ar_pre_plot: got %h, want 14d", {plot, x});
    end
    #2 reset = 1'b0;
    #1;
    check_quiet("ar_immediate");
    checks++;
    if ({x, timeout_flag} !== 9'd0) begin
      errors++;
      $display("FAIL ar_data: got %h, want 0", {x, timeout_flag});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_quiet("ar_no_start");
      frame_tick = (i % 2 == 0);
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_sequence();
    test_back_to_back();
    test_watchdog();
    test_game_over();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
